// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO of any depth with standard or
// first-word-fall-through read, almost flags, flush and sticky error flags.
module sync_fifo_flex #(
   parameter int DATA_WIDTH   = 32,
   parameter int DATA_DEPTH   = 8,
   parameter bit FWFT         = 1'b0,
   parameter int ALMOST_FULL  = 6,
   parameter int ALMOST_EMPTY = 2
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            flush,
   input  logic                            wr_en,
   input  logic [DATA_WIDTH-1:0]           wr_data,
   input  logic                            rd_en,
   output logic [DATA_WIDTH-1:0]           rd_data,
   output logic                            rd_valid,
   output logic                            full,
   output logic                            empty,
   output logic                            almost_full,
   output logic                            almost_empty,
   output logic [$clog2(DATA_DEPTH+1)-1:0] count,
   output logic                            overflow,
   output logic                            underflow
);

   localparam int CW = $clog2(DATA_DEPTH + 1);
   localparam int PW = $clog2(DATA_DEPTH);
   localparam logic [PW-1:0] LAST = PW'(DATA_DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DATA_DEPTH);

   logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  rd_valid_q;
   logic                  rd_acc;
   logic                  wr_acc;
   logic                  bypass;

   // Depth need not be a power of two, so wrap on the last index.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + PW'(1);
   endfunction

   assign empty        = (count == '0);
   assign full         = (count == FULL_CNT);
   assign almost_full  = (count >= CW'(ALMOST_FULL));
   assign almost_empty = (count <= CW'(ALMOST_EMPTY));

   assign rd_acc = rd_en & ~empty;
   assign bypass = !FWFT & rd_en & wr_en & empty;
   assign wr_acc = wr_en & (~full | rd_acc) & ~bypass;

   assign rd_valid = FWFT ? ~empty : rd_valid_q;
   assign rd_data  = FWFT ? (empty ? '0 : mem[rd_ptr]) : rd_data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count      <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else if (flush) begin
         count      <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         rd_valid_q <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         rd_valid_q <= 1'b0;
         if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
         if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
         if (wr_acc & ~rd_acc)
            count <= count + CW'(1);
         else if (rd_acc & ~wr_acc)
            count <= count - CW'(1);
         if (wr_en & full & ~rd_acc) overflow <= 1'b1;
         if (rd_en & empty & (FWFT | ~wr_en)) underflow <= 1'b1;
         if (!FWFT && rd_acc) begin
            rd_data_q  <= mem[rd_ptr];
            rd_valid_q <= 1'b1;
         end else if (bypass) begin
            rd_data_q  <= wr_data;
            rd_valid_q <= 1'b1;
         end
      end
   end

   // Storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wr_acc && !flush) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb_sync_fifo_flex: three FIFO variants on shared stimulus, checked
// every cycle against a list-based model plus directed literals.
module tb_sync_fifo_flex;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        wr_en;
   logic [31:0] wr_data;
   logic        rd_en;

   logic [31:0] o_data [3];
   logic        o_valid [3];
   logic        o_full [3];
   logic        o_empty [3];
   logic        o_af [3];
   logic        o_ae [3];
   logic        o_ov [3];
   logic        o_un [3];
   logic [2:0]  cnt0;
   logic [3:0]  cnt1;
   logic [3:0]  cnt2;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   logic [31:0] mq [3][8];
   int          mn [3];
   logic [31:0] mrd [3];
   bit          mrv [3];
   bit          mov [3];
   bit          mun [3];

   sync_fifo_flex #(.DATA_WIDTH(32), .DATA_DEPTH(5), .FWFT(1'b0),
      .ALMOST_FULL(4), .ALMOST_EMPTY(1)) u0 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en),
      .wr_data(wr_data), .rd_en(rd_en), .rd_data(o_data[0]),
      .rd_valid(o_valid[0]), .full(o_full[0]), .empty(o_empty[0]),
      .almost_full(o_af[0]), .almost_empty(o_ae[0]), .count(cnt0),
      .overflow(o_ov[0]), .underflow(o_un[0]));

   sync_fifo_flex #(.DATA_WIDTH(32), .DATA_DEPTH(8), .FWFT(1'b0),
      .ALMOST_FULL(6), .ALMOST_EMPTY(2)) u1 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en),
      .wr_data(wr_data), .rd_en(rd_en), .rd_data(o_data[1]),
      .rd_valid(o_valid[1]), .full(o_full[1]), .empty(o_empty[1]),
      .almost_full(o_af[1]), .almost_empty(o_ae[1]), .count(cnt1),
      .overflow(o_ov[1]), .underflow(o_un[1]));

   sync_fifo_flex #(.DATA_WIDTH(32), .DATA_DEPTH(8), .FWFT(1'b1),
      .ALMOST_FULL(6), .ALMOST_EMPTY(2)) u2 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en),
      .wr_data(wr_data), .rd_en(rd_en), .rd_data(o_data[2]),
      .rd_valid(o_valid[2]), .full(o_full[2]), .empty(o_empty[2]),
      .almost_full(o_af[2]), .almost_empty(o_ae[2]), .count(cnt2),
      .overflow(o_ov[2]), .underflow(o_un[2]));

   initial clk = 0;
   always #5 clk = ~clk;

   function automatic int dep(input int i);
      return (i == 0) ? 5 : 8;
   endfunction
   function automatic bit fwf(input int i);
      return i == 2;
   endfunction
   function automatic int afl(input int i);
      return (i == 0) ? 4 : 6;
   endfunction
   function automatic int ael(input int i);
      return (i == 0) ? 1 : 2;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         mn[i] = 0; mrd[i] = '0; mrv[i] = 0; mov[i] = 0; mun[i] = 0;
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < 3; i++) begin
         bit e, f, ro, by, wo;
         if (flush) begin
            mn[i] = 0; mov[i] = 0; mun[i] = 0; mrv[i] = 0;
         end else begin
            e  = (mn[i] == 0);
            f  = (mn[i] == dep(i));
            ro = rd_en && !e;
            by = !fwf(i) && rd_en && wr_en && e;
            wo = wr_en && (!f || ro) && !by;
            mrv[i] = 0;
            if (wr_en && !wo && !by) mov[i] = 1;
            if (rd_en && e && (fwf(i) || !wr_en)) mun[i] = 1;
            if (ro && !fwf(i)) begin mrd[i] = mq[i][0]; mrv[i] = 1; end
            if (by) begin mrd[i] = wr_data; mrv[i] = 1; end
            if (ro) begin
               for (int k = 0; k < 7; k++) mq[i][k] = mq[i][k+1];
               mn[i]--;
            end
            if (wo) begin mq[i][mn[i]] = wr_data; mn[i]++; end
         end
      end
   endtask

   task automatic cmp_all();
      logic [31:0] c;
      for (int i = 0; i < 3; i++) begin
         c = (i == 0) ? {29'd0, cnt0} : (i == 1) ? {28'd0, cnt1} : {28'd0, cnt2};
         chk($sformatf("u%0d.count", i), c, mn[i]);
         chk($sformatf("u%0d.empty", i), o_empty[i], mn[i] == 0);
         chk($sformatf("u%0d.full", i), o_full[i], mn[i] == dep(i));
         chk($sformatf("u%0d.af", i), o_af[i], mn[i] >= afl(i));
         chk($sformatf("u%0d.ae", i), o_ae[i], mn[i] <= ael(i));
         chk($sformatf("u%0d.ovf", i), o_ov[i], mov[i]);
         chk($sformatf("u%0d.unf", i), o_un[i], mun[i]);
         if (fwf(i)) begin
            chk($sformatf("u%0d.valid", i), o_valid[i], mn[i] != 0);
            if (mn[i] != 0) chk($sformatf("u%0d.data", i), o_data[i], mq[i][0]);
         end else begin
            chk($sformatf("u%0d.valid", i), o_valid[i], mrv[i]);
            chk($sformatf("u%0d.data", i), o_data[i], mrd[i]);
         end
      end
   endtask

   always @(negedge clk) if (chk_en) cmp_all();

   task automatic cyc(input bit f, input bit w, input logic [31:0] d,
                      input bit r);
      flush = f; wr_en = w; wr_data = d; rd_en = r;
      @(posedge clk);
      if (rst_n) model_step();
      @(negedge clk);
      flush = 0; wr_en = 0; rd_en = 0;
   endtask

   initial begin
      rst_n = 0; flush = 0; wr_en = 0; wr_data = '0; rd_en = 0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst.count", {28'd0, cnt1}, 0);
      chk("rst.empty", o_empty[1], 1);
      chk("rst.full", o_full[1], 0);
      chk("rst.ae", o_ae[1], 1);
      chk("rst.af", o_af[1], 0);
      chk("rst.valid", o_valid[1], 0);
      chk("rst.data", o_data[1], 0);
      rst_n = 1;
      chk_en = 1;

      // fill depth-5, overflow, drain in order
      for (int k = 1; k <= 5; k++) cyc(0, 1, k, 0);
      chk("t1.count5", {29'd0, cnt0}, 5);
      chk("t1.full", o_full[0], 1);
      cyc(0, 1, 6, 0);
      chk("t1.ovf", o_ov[0], 1);
      chk("t1.count_hold", {29'd0, cnt0}, 5);
      for (int k = 1; k <= 5; k++) begin
         cyc(0, 0, 0, 1);
         chk("t1.rd_data", o_data[0], k);
         chk("t1.rd_valid", o_valid[0], 1);
      end
      chk("t1.empty", o_empty[0], 1);
      cyc(1, 0, 0, 0);
      chk("t1.flush_ovf", o_ov[0], 0);

      // pointer wrap on depth 5
      for (int k = 0; k < 12; k++) begin
         cyc(0, 1, 32'h100 + k, 0);
         cyc(0, 0, 0, 1);
         chk("t2.rd_data", o_data[0], 32'h100 + k);
      end
      chk("t2.empty", o_empty[0], 1);

      // bypass on empty, standard mode; FWFT flags underflow and stores
      cyc(0, 1, 32'hAA, 1);
      chk("t3.data", o_data[0], 32'hAA);
      chk("t3.valid", o_valid[0], 1);
      chk("t3.count", {29'd0, cnt0}, 0);
      chk("t3.fwft_unf", o_un[2], 1);
      chk("t3.fwft_count", {28'd0, cnt2}, 1);
      cyc(1, 0, 0, 0);

      // fill depth 8, almost levels, read+write while full
      for (int k = 0; k < 8; k++) begin
         cyc(0, 1, 32'h200 + k, 0);
         chk("t6.ae", o_ae[1], (k + 1) <= 2);
         chk("t6.af", o_af[1], (k + 1) >= 6);
      end
      chk("t4.full", o_full[1], 1);
      cyc(0, 1, 32'h55, 1);
      chk("t4.data", o_data[1], 32'h200);
      chk("t4.count", {28'd0, cnt1}, 8);
      chk("t4.ovf", o_ov[1], 0);
      for (int k = 0; k < 8; k++) cyc(0, 0, 0, 1);
      chk("t4.last", o_data[1], 32'h55);
      chk("t4.empty", o_empty[1], 1);
      cyc(1, 0, 0, 0);

      // FWFT head visibility, pop, underflow, flush
      cyc(0, 1, 32'h11, 0);
      chk("t5.data", o_data[2], 32'h11);
      chk("t5.valid", o_valid[2], 1);
      cyc(0, 0, 0, 0);
      chk("t5.hold", o_data[2], 32'h11);
      cyc(0, 0, 0, 1);
      chk("t5.empty", o_empty[2], 1);
      cyc(0, 0, 0, 1);
      chk("t5.unf", o_un[2], 1);
      cyc(1, 0, 0, 0);
      chk("t5.flush_unf", o_un[2], 0);
      chk("t5.flush_cnt", {28'd0, cnt2}, 0);

      // async reset mid-fill
      for (int k = 0; k < 4; k++) cyc(0, 1, 32'h300 + k, 0);
      chk("t6.pre", {28'd0, cnt1}, 4);
      #2 rst_n = 0;
      model_reset();
      #1;
      chk("t6.async_cnt", {28'd0, cnt1}, 0);
      chk("t6.async_empty", o_empty[1], 1);
      @(negedge clk);
      rst_n = 1;

      // mixed traffic
      for (int k = 0; k < 200; k++)
         cyc($urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
             $urandom, $urandom_range(0, 2) != 0);

      chk_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
